// File: rtl/decode_stage.sv
// -----------------------------------------------------------------------------
// decode_stage
//
// Single-slot registered decode stage for a small ARM64-like subset. Each
// accepted 32-bit instruction word is decoded combinationally and captured,
// together with its PC, into the output register. The decoded result appears
// one cycle later. A valid/ready handshake is used on both sides. Flush drops
// the held result and blocks intake for that cycle.
//
// Optional feature:
//   DECODE_EXT_EN - when defined, CBNZ (op 12) and SUBI (op 13) are decoded.
//                   When undefined, those encodings decode as illegal.
//
// Parameters:
//   XLEN  - immediate/PC datapath width (32..64)
//   CNT_W - width of the saturating illegal-instruction counter
//
// Ports:
//   clk, rst_n            - rising-edge clock, asynchronous active-low reset
//   in_valid/in_ready     - upstream handshake
//   in_inst, in_pc        - instruction word and its PC
//   flush                 - discard held output, block intake this cycle
//   out_valid/out_ready   - downstream handshake
//   out_op, out_illegal   - opcode encoding and illegal flag
//   out_rm/rn/rd/shamt/cond - raw register/shift/condition fields
//   out_imm, out_pc       - selected immediate and pass-through PC
//   err_cnt               - count of accepted illegal words (saturating)
// -----------------------------------------------------------------------------
module decode_stage #(
    parameter int XLEN  = 64,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_inst,
    input  logic [XLEN-1:0]  in_pc,
    input  logic             flush,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [3:0]       out_op,
    output logic             out_illegal,
    output logic [4:0]       out_rm,
    output logic [4:0]       out_rn,
    output logic [4:0]       out_rd,
    output logic [5:0]       out_shamt,
    output logic [3:0]       out_cond,
    output logic [XLEN-1:0]  out_imm,
    output logic [XLEN-1:0]  out_pc,
    output logic [CNT_W-1:0] err_cnt
);

    localparam logic [3:0] OP_NONE = 4'd0;
    localparam logic [3:0] OP_ADDI = 4'd1;
    localparam logic [3:0] OP_ADDS = 4'd2;
    localparam logic [3:0] OP_BLT  = 4'd3;
    localparam logic [3:0] OP_B    = 4'd4;
    localparam logic [3:0] OP_CBZ  = 4'd5;
    localparam logic [3:0] OP_LDUR = 4'd6;
    localparam logic [3:0] OP_LSL  = 4'd7;
    localparam logic [3:0] OP_LSR  = 4'd8;
    localparam logic [3:0] OP_MUL  = 4'd9;
    localparam logic [3:0] OP_STUR = 4'd10;
    localparam logic [3:0] OP_SUBS = 4'd11;
`ifdef DECODE_EXT_EN
    localparam logic [3:0] OP_CBNZ = 4'd12;
    localparam logic [3:0] OP_SUBI = 4'd13;
`endif

    // Immediate source formats (unscaled)
    typedef enum logic [2:0] {
        IMM_ZERO,
        IMM_U12,    // inst[21:10] zero-extended
        IMM_S26,    // inst[25:0]  sign-extended
        IMM_S19,    // inst[23:5]  sign-extended
        IMM_S9      // inst[20:12] sign-extended
    } imm_sel_t;

    // ---------------------------------------------------------------------
    // Combinational decode of the incoming word
    // ---------------------------------------------------------------------
    logic [3:0]      dec_op;
    logic            dec_illegal;
    imm_sel_t        dec_imm_sel;
    logic [XLEN-1:0] dec_imm;

    always_comb begin
        dec_op      = OP_NONE;
        dec_illegal = 1'b0;
        dec_imm_sel = IMM_ZERO;

        if (in_inst[31:26] == 6'h05) begin
            dec_op      = OP_B;
            dec_imm_sel = IMM_S26;
        end else if (in_inst[31:24] == 8'hB4) begin
            dec_op      = OP_CBZ;
            dec_imm_sel = IMM_S19;
        end else if (in_inst[31:24] == 8'h54 && in_inst[4:0] == 5'h0B) begin
            dec_op      = OP_BLT;
            dec_imm_sel = IMM_S19;
        end else if (in_inst[31:22] == 10'h244) begin
            dec_op      = OP_ADDI;
            dec_imm_sel = IMM_U12;
`ifdef DECODE_EXT_EN
        end else if (in_inst[31:24] == 8'hB5) begin
            dec_op      = OP_CBNZ;
            dec_imm_sel = IMM_S19;
        end else if (in_inst[31:22] == 10'h344) begin
            dec_op      = OP_SUBI;
            dec_imm_sel = IMM_U12;
`endif
        end else begin
            unique case (in_inst[31:21])
                11'h69A: dec_op = OP_LSR;
                11'h69B: dec_op = OP_LSL;
                11'h758: dec_op = OP_SUBS;
                11'h7C0: begin
                    dec_op      = OP_STUR;
                    dec_imm_sel = IMM_S9;
                end
                11'h7C2: begin
                    dec_op      = OP_LDUR;
                    dec_imm_sel = IMM_S9;
                end
                11'h558: dec_op = OP_ADDS;
                // MUL is only legal with the Ra field (shamt slot) = XZR
                11'h4D8: begin
                    if (in_inst[15:10] == 6'h1F) begin
                        dec_op = OP_MUL;
                    end else begin
                        dec_illegal = 1'b1;
                    end
                end
                default: dec_illegal = 1'b1;
            endcase
        end
    end

    always_comb begin
        dec_imm = '0;
        unique case (dec_imm_sel)
            IMM_U12: dec_imm = {{(XLEN-12){1'b0}}, in_inst[21:10]};
            IMM_S26: dec_imm = {{(XLEN-26){in_inst[25]}}, in_inst[25:0]};
            IMM_S19: dec_imm = {{(XLEN-19){in_inst[23]}}, in_inst[23:5]};
            IMM_S9:  dec_imm = {{(XLEN-9){in_inst[20]}}, in_inst[20:12]};
            default: dec_imm = '0;
        endcase
    end

    // ---------------------------------------------------------------------
    // Handshake and output register
    // ---------------------------------------------------------------------
    logic             valid_reg;
    logic [3:0]       op_reg;
    logic             illegal_reg;
    logic [31:0]      inst_reg;
    logic [XLEN-1:0]  imm_reg;
    logic [XLEN-1:0]  pc_reg;
    logic [CNT_W-1:0] err_reg;
    logic             accept;

    // rst_n is included so in_ready is low for the whole reset interval
    assign in_ready = rst_n && !flush && (!valid_reg || out_ready);
    assign accept   = in_valid && in_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_reg   <= 1'b0;
            op_reg      <= OP_NONE;
            illegal_reg <= 1'b0;
            inst_reg    <= '0;
            imm_reg     <= '0;
            pc_reg      <= '0;
            err_reg     <= '0;
        end else begin
            if (flush) begin
                valid_reg <= 1'b0;
            end else if (accept) begin
                valid_reg   <= 1'b1;
                op_reg      <= dec_op;
                illegal_reg <= dec_illegal;
                inst_reg    <= in_inst;
                imm_reg     <= dec_imm;
                pc_reg      <= in_pc;
            end else if (valid_reg && out_ready) begin
                valid_reg <= 1'b0;
            end

            // accept already excludes flush cycles
            if (accept && dec_illegal && (err_reg != {CNT_W{1'b1}})) begin
                err_reg <= err_reg + {{(CNT_W-1){1'b0}}, 1'b1};
            end
        end
    end

    // Register fields are raw slices of the captured word, for every opcode
    assign out_valid   = valid_reg;
    assign out_op      = op_reg;
    assign out_illegal = illegal_reg;
    assign out_rm      = inst_reg[20:16];
    assign out_rn      = inst_reg[9:5];
    assign out_rd      = inst_reg[4:0];
    assign out_shamt   = inst_reg[15:10];
    assign out_cond    = inst_reg[3:0];
    assign out_imm     = imm_reg;
    assign out_pc      = pc_reg;
    assign err_cnt     = err_reg;

endmodule

// File: tb/tb_decode_stage.sv
// -----------------------------------------------------------------------------
// tb_decode_stage
//
// Scoreboard bench for decode_stage (XLEN=64, CNT_W=2). Expected results are
// pushed when a transfer is accepted on the input side and popped/compared
// when the output transfers or is flushed. A held output is compared against
// the scoreboard head every cycle it stays valid.
// -----------------------------------------------------------------------------
module tb_decode_stage;

    localparam int XLEN  = 64;
    localparam int CNT_W = 2;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             in_valid;
    logic             in_ready;
    logic [31:0]      in_inst;
    logic [XLEN-1:0]  in_pc;
    logic             flush;
    logic             out_valid;
    logic             out_ready;
    logic [3:0]       out_op;
    logic             out_illegal;
    logic [4:0]       out_rm;
    logic [4:0]       out_rn;
    logic [4:0]       out_rd;
    logic [5:0]       out_shamt;
    logic [3:0]       out_cond;
    logic [XLEN-1:0]  out_imm;
    logic [XLEN-1:0]  out_pc;
    logic [CNT_W-1:0] err_cnt;

    decode_stage #(.XLEN(XLEN), .CNT_W(CNT_W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_inst    (in_inst),
        .in_pc      (in_pc),
        .flush      (flush),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_op     (out_op),
        .out_illegal(out_illegal),
        .out_rm     (out_rm),
        .out_rn     (out_rn),
        .out_rd     (out_rd),
        .out_shamt  (out_shamt),
        .out_cond   (out_cond),
        .out_imm    (out_imm),
        .out_pc     (out_pc),
        .err_cnt    (err_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] inst;
        logic [3:0]  op;
        logic        ill;
        logic [63:0] imm;
        logic [63:0] pc;
    } exp_t;

    exp_t             sb_q[$];
    exp_t             tbl[$];
    exp_t             cur_exp;
    exp_t             hd;
    exp_t             ent;
    int               total = 0;
    int               bad   = 0;
    int unsigned      cyc   = 0;
    logic [CNT_W-1:0] exp_err = '0;
    bit               rnd_on = 1'b0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h expected=%h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Random downstream backpressure during the random phase
    always @(posedge clk) begin
        if (rnd_on) begin
            #1;
            out_ready = ($urandom_range(0, 1) == 1);
        end
    end

    // Scoreboard monitor, sampling away from the active edge
    always @(negedge clk) begin
        if (!rst_n) begin
            sb_q.delete();
            exp_err = '0;
            chk("rst_valid", out_valid, 0);
            chk("rst_ready", in_ready, 0);
        end else begin
            chk("valid", out_valid, sb_q.size() != 0);
            chk("in_ready", in_ready, !flush && (!out_valid || out_ready));
            chk("err_cnt", err_cnt, exp_err);
            if (out_valid && sb_q.size() != 0) begin
                hd = sb_q[0];
                chk("op",      out_op,      hd.op);
                chk("illegal", out_illegal, hd.ill);
                chk("imm",     out_imm,     hd.imm);
                chk("pc",      out_pc,      hd.pc);
                chk("rd",      out_rd,      hd.inst[4:0]);
                chk("rn",      out_rn,      hd.inst[9:5]);
                chk("rm",      out_rm,      hd.inst[20:16]);
                chk("shamt",   out_shamt,   hd.inst[15:10]);
                chk("cond",    out_cond,    hd.inst[3:0]);
                if (flush) begin
                    void'(sb_q.pop_front());
                    $display("flushed inst=%h", hd.inst);
                end else if (out_ready) begin
                    void'(sb_q.pop_front());
                    $display("xfer inst=%h op=%0d ill=%0b imm=%h pc=%h err=%0d",
                             hd.inst, out_op, out_illegal, out_imm, out_pc, err_cnt);
                end
            end
            if (in_valid && in_ready) begin
                ent      = cur_exp;
                ent.inst = in_inst;
                ent.pc   = in_pc;
                sb_q.push_back(ent);
                if (cur_exp.ill && exp_err != {CNT_W{1'b1}}) exp_err = exp_err + 1'b1;
            end
        end
    end

    task automatic add(input logic [31:0] inst, input logic [3:0] op, input logic ill,
                       input logic [63:0] imm);
        exp_t e;
        e.inst = inst; e.op = op; e.ill = ill; e.imm = imm; e.pc = '0;
        tbl.push_back(e);
    endtask

    task automatic drive(input logic [31:0] inst, input logic [3:0] op, input logic ill,
                         input logic [63:0] imm);
        in_valid     = 1'b1;
        in_inst      = inst;
        in_pc        = {$urandom, $urandom};
        cur_exp.inst = inst;
        cur_exp.op   = op;
        cur_exp.ill  = ill;
        cur_exp.imm  = imm;
        cur_exp.pc   = in_pc;
    endtask

    // Called at posedge+1; returns at posedge+1 after the accepting edge
    task automatic send(input logic [31:0] inst, input logic [3:0] op, input logic ill,
                        input logic [63:0] imm);
        bit done = 1'b0;
        drive(inst, op, ill, imm);
        for (int i = 0; i < 50 && !done; i++) begin
            @(negedge clk);
            if (in_ready) done = 1'b1;
            @(posedge clk);
            #1;
        end
        if (!done) chk("send_timeout", 0, 1);
    endtask

    task automatic send_e(input exp_t e);
        send(e.inst, e.op, e.ill, e.imm);
    endtask

    task automatic idle();
        in_valid = 1'b0;
    endtask

    task automatic do_reset();
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_valid", out_valid, 0);
        chk("arst_ready", in_ready, 0);
        chk("arst_err",   err_cnt, 0);
        chk("arst_op",    out_op, 0);
        chk("arst_imm",   out_imm, 0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        int unsigned c0;
        int unsigned c1;
        logic [CNT_W-1:0] e0;

        rst_n = 1'b0; in_valid = 1'b0; in_inst = '0; in_pc = '0;
        flush = 1'b0; out_ready = 1'b1;
        cur_exp = '{default: '0};

        add(32'h91001441, 4'd1,  1'b0, 64'd5);
        add(32'h913FFC00, 4'd1,  1'b0, 64'hFFF);
        add(32'h17FFFFFF, 4'd4,  1'b0, 64'hFFFF_FFFF_FFFF_FFFF);
        add(32'h14000010, 4'd4,  1'b0, 64'h10);
        add(32'hB4000041, 4'd5,  1'b0, 64'd2);
        add(32'hB4FFFFE0, 4'd5,  1'b0, 64'hFFFF_FFFF_FFFF_FFFF);
        add(32'h5400004B, 4'd3,  1'b0, 64'd2);
        add(32'h5400004A, 4'd0,  1'b1, 64'd0);
        add(32'hF85FF041, 4'd6,  1'b0, 64'hFFFF_FFFF_FFFF_FFFF);
        add(32'hF8008062, 4'd10, 1'b0, 64'd8);
        add(32'hD3401020, 4'd8,  1'b0, 64'd0);
        add(32'hD3600C41, 4'd7,  1'b0, 64'd0);
        add(32'hEB020020, 4'd11, 1'b0, 64'd0);
        add(32'hAB020020, 4'd2,  1'b0, 64'd0);
        add(32'h9B027C20, 4'd9,  1'b0, 64'd0);
        add(32'h9B020020, 4'd0,  1'b1, 64'd0);
        add(32'h00000000, 4'd0,  1'b1, 64'd0);
`ifdef DECODE_EXT_EN
        add(32'hB5000041, 4'd12, 1'b0, 64'd2);
        add(32'hD1000C41, 4'd13, 1'b0, 64'd3);
`else
        add(32'hB5000041, 4'd0,  1'b1, 64'd0);
        add(32'hD1000C41, 4'd0,  1'b1, 64'd0);
`endif

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        chk("rst_op",  out_op, 0);
        chk("rst_ill", out_illegal, 0);
        chk("rst_imm", out_imm, 0);
        chk("rst_pc",  out_pc, 0);
        chk("rst_rd",  out_rd, 0);
        chk("rst_err", err_cnt, 0);
        rst_n = 1'b1;

        // ADDI directed
        send(32'h91001441, 4'd1, 1'b0, 64'd5);
        idle();
        @(negedge clk);
        chk("addi_valid", out_valid, 1);
        chk("addi_op",    out_op, 1);
        chk("addi_rd",    out_rd, 1);
        chk("addi_rn",    out_rn, 2);
        chk("addi_imm",   out_imm, 5);
        chk("addi_ill",   out_illegal, 0);
        @(posedge clk); #1;

        // B with all-ones offset
        send(32'h17FFFFFF, 4'd4, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF);
        idle();
        @(negedge clk);
        chk("b_op",  out_op, 4);
        chk("b_imm", out_imm, 64'hFFFF_FFFF_FFFF_FFFF);
        @(posedge clk); #1;

        // MUL legal then MUL with bad shamt
        send(32'h9B027C20, 4'd9, 1'b0, 64'd0);
        idle();
        @(negedge clk);
        chk("mul_op", out_op, 9);
        e0 = err_cnt;
        @(posedge clk); #1;
        send(32'h9B020020, 4'd0, 1'b1, 64'd0);
        idle();
        @(negedge clk);
        chk("mulbad_op",  out_op, 0);
        chk("mulbad_ill", out_illegal, 1);
        chk("mulbad_err", err_cnt, e0 + 1'b1);
        @(posedge clk); #1;

        // Extension encoding
        send(32'hB5000041, tbl[17].op, tbl[17].ill, tbl[17].imm);
        idle();
        @(negedge clk);
`ifdef DECODE_EXT_EN
        chk("cbnz_op",  out_op, 12);
        chk("cbnz_ill", out_illegal, 0);
`else
        chk("cbnz_op",  out_op, 0);
        chk("cbnz_ill", out_illegal, 1);
`endif
        @(posedge clk); #1;

        // Back-to-back stream: one word per cycle
        c0 = cyc;
        foreach (tbl[i]) send_e(tbl[i]);
        c1 = cyc;
        idle();
        chk("throughput", c1 - c0, tbl.size());
        repeat (2) @(posedge clk); #1;

        // Saturation at 2^CNT_W-1 after a fresh reset
        do_reset();
        repeat (5) send(32'h00000000, 4'd0, 1'b1, 64'd0);
        idle();
        @(negedge clk);
        chk("err_sat", err_cnt, 3);
        @(posedge clk); #1;

        // Backpressure: 3 stalled cycles with in_valid held high
        out_ready = 1'b0;
        send(32'hF8008062, 4'd10, 1'b0, 64'd8);
        drive(32'hEB020020, 4'd11, 1'b0, 64'd0);
        repeat (3) begin
            @(negedge clk);
            chk("bp_ready", in_ready, 0);
            chk("bp_hold_op", out_op, 10);
            @(posedge clk); #1;
        end
        out_ready = 1'b1;
        send(32'hEB020020, 4'd11, 1'b0, 64'd0);
        idle();
        @(negedge clk);
        chk("bp_after_op", out_op, 11);
        @(posedge clk); #1;

        // Flush with a held output; intake blocked during flush
        out_ready = 1'b0;
        send(32'hD3600C41, 4'd7, 1'b0, 64'd0);
        e0 = err_cnt;
        flush = 1'b1;
        drive(32'h00000000, 4'd0, 1'b1, 64'd0);
        @(posedge clk); #1;
        flush = 1'b0;
        in_valid = 1'b0;
        @(negedge clk);
        chk("flush_valid", out_valid, 0);
        chk("flush_err",   err_cnt, e0);
        out_ready = 1'b1;
        @(posedge clk); #1;

        // Reset while an output is held
        out_ready = 1'b0;
        send(32'h91001441, 4'd1, 1'b0, 64'd5);
        idle();
        do_reset();
        out_ready = 1'b1;
        send(32'hAB020020, 4'd2, 1'b0, 64'd0);
        idle();
        @(negedge clk);
        chk("post_rst_op", out_op, 2);
        @(posedge clk); #1;

        // Random traffic with random backpressure
        rnd_on = 1'b1;
        for (int i = 0; i < 40; i++) begin
            send_e(tbl[$urandom_range(0, tbl.size() - 1)]);
            if ($urandom_range(0, 3) == 0) begin
                idle();
                @(posedge clk); #1;
            end
        end
        idle();
        rnd_on = 1'b0;
        @(posedge clk); #2;
        out_ready = 1'b1;
        repeat (4) @(posedge clk);
        #1;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        chk("watchdog", 0, 1);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/decode_stage.md
DECODE_STAGE -- requirements
Module: decode_stage

Interface
REQ-001 SHALL have parameter XLEN, default 64, immediate/PC datapath width; legal range 32..64.
REQ-002 SHALL have parameter CNT_W, default 8, width of the illegal-instruction counter.
REQ-003 SHALL have port clk, input, 1, single rising-edge clock.
REQ-004 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-005 SHALL have ports in_valid (input, 1), in_ready (output, 1), in_inst (input, 32) and in_pc (input, XLEN), forming the upstream handshake, instruction word and its PC.
REQ-006 SHALL have port flush, input, 1, which discards the held output and blocks intake.
REQ-007 SHALL have ports out_valid (output, 1) and out_ready (input, 1), forming the downstream handshake.
REQ-008 SHALL have outputs out_op (4, opcode), out_illegal (1), out_rm/out_rn/out_rd (5 each), out_shamt (6), out_cond (4), out_imm (XLEN) and out_pc (XLEN).
REQ-009 SHALL have output err_cnt, CNT_W bits, counting illegal instructions.

Function
REQ-010 SHALL encode out_op as: 0=none/illegal, 1=ADDI, 2=ADDS, 3=BLT, 4=B, 5=CBZ, 6=LDUR, 7=LSL, 8=LSR, 9=MUL, 10=STUR, 11=SUBS.
REQ-011 SHALL decode in priority order:
- B: inst[31:26]=0x05
- CBZ: inst[31:24]=0xB4
- BLT: inst[31:24]=0x54 and inst[4:0]=0x0B
- ADDI: inst[31:22]=0x244
- on inst[31:21]: 0x69A LSR, 0x69B LSL, 0x758 SUBS, 0x7C0 STUR, 0x7C2 LDUR, 0x558 ADDS, 0x4D8 MUL.
REQ-012 SHALL decode MUL only when inst[15:10]=0x1F; any other shamt gives out_op=0 and out_illegal=1.
REQ-013 SHALL give out_op=0 and out_illegal=1 for any unmatched word; it SHALL NOT halt simulation.
REQ-014 SHALL drive register fields as rm=inst[20:16], rn=inst[9:5], rd=inst[4:0], shamt=inst[15:10], cond=inst[3:0], for every opcode.
REQ-015 SHALL select out_imm by opcode, unscaled:
- ADDI: inst[21:10] zero-extended to XLEN
- B: inst[25:0] sign-extended
- CBZ/BLT: inst[23:5] sign-extended
- LDUR/STUR: inst[20:12] sign-extended
- all others: 0.
REQ-016 SHALL copy in_pc unchanged to out_pc.
REQ-017 SHALL register all outputs: a word accepted in cycle N appears with out_valid=1 in cycle N+1 (latency 1).
REQ-018 SHALL drive in_ready = !flush && (!out_valid || out_ready), giving full throughput with no bubbles under continuous valid/ready.
REQ-019 SHALL accept a transfer when in_valid && in_ready, and load the output register with its decode.
REQ-020 SHALL clear out_valid when out_valid && out_ready and no new transfer is accepted in the same cycle.
REQ-021 SHALL hold all out_* stable while out_valid && !out_ready.
REQ-022 SHALL clear out_valid next cycle when flush=1, regardless of out_ready; no intake occurs that cycle.
REQ-023 SHALL increment err_cnt by 1 on each accepted transfer decoded illegal, and saturate at 2^CNT_W-1.
REQ-024 SHALL ignore in_inst, in_pc and illegal status when no transfer is accepted; err_cnt does not change.

Reset
REQ-025 SHALL, on rst_n low and asynchronously, force out_valid=0, err_cnt=0, out_op=0, out_illegal=0 and all other out_* to 0.
REQ-026 SHALL drive in_ready=0 while rst_n=0.
REQ-027 SHALL drop any transfer in flight when reset asserts mid-operation; it is not replayed.
REQ-028 SHALL release reset on rst_n high, with the first acceptance possible on the next rising edge.

Configuration
REQ-029 SHALL support macro DECODE_EXT_EN; when it is defined:
- inst[31:24]=0xB5 decodes as CBNZ, op=12, imm as for CBZ
- inst[31:22]=0x344 decodes as SUBI, op=13, imm as for ADDI
- both are checked after ADDI and before the 11-bit table.
REQ-030 SHALL, when DECODE_EXT_EN is undefined, decode those encodings as illegal; ops 12..15 never appear.

Verification
REQ-031 SHALL verify: accept 0x91001441 -> next cycle out_valid=1, op=1, rd=1, rn=2, imm=5, illegal=0.
REQ-032 SHALL verify: accept 0x17FFFFFF with XLEN=64 -> op=4, imm=0xFFFF_FFFF_FFFF_FFFF.
REQ-033 SHALL verify: accept 0x9B027C20 -> op=9; accept 0x9B020020 -> op=0, illegal=1, err_cnt increments by 1.
REQ-034 SHALL verify: CNT_W=2, with 5 accepted 0x00000000 words -> err_cnt=3 (saturated).
REQ-035 SHALL verify backpressure and flush:
- out_ready=0 for 3 cycles with in_valid=1 -> in_ready=0, outputs held, one word transferred after release
- flush with out_valid=1 -> out_valid=0 next cycle and err_cnt unchanged.
REQ-036 SHALL verify: accept 0xB5000041 -> op=12 with DECODE_EXT_EN defined; op=0, illegal=1 without it.
